// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared widths, command record and sequencer state type for the EEPROM command path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eeprom_pkg;

  localparam int EE_AW = 11;
  localparam int EE_DW = 8;

  // One queued host request: direction, byte address and write byte.
  typedef struct packed {
    logic             wr;
    logic [EE_AW-1:0] addr;
    logic [EE_DW-1:0] data;
  } ee_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ee_state_t;

endpackage

// File: rtl/eeprom_req_fifo.sv
// eeprom_req_fifo: synchronous FIFO of ee_cmd_t between the host port and the sequencer FSM.
// Latency: an entry pushed at edge k is visible at the head (empty=0) after edge k.
// Backpressure: full is derived from the registered count; pushes while full and pops while empty are dropped.
module eeprom_req_fifo
  import eeprom_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  ee_cmd_t                push_dat,
  input  logic                   pop,
  output ee_cmd_t                pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ee_cmd_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_dat = r_mem[r_rptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eeprom_cmd_seq.sv
// eeprom_cmd_seq: queues host read/write requests and runs them one at a time on the EEPROM controller.
// Latency: request accepted at edge k raises WR/RD after edge k+1; rsp_valid pulses the cycle after the ACK edge.
// Backpressure: req_ready = FIFO not full; responses cannot be stalled. Option: EEPROM_TIMEOUT_EN adds the ACK watchdog.
module eeprom_cmd_seq
  import eeprom_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [EE_AW-1:0] req_addr,
  input  logic [EE_DW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [EE_DW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic             WR,
  output logic             RD,
  output logic [EE_AW-1:0] ADDR,
  inout  wire  [EE_DW-1:0] DATA,
  input  logic             ACK
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ee_state_t        r_state;
  logic             r_wr;
  logic             r_rd;
  logic             r_drive;
  logic [EE_AW-1:0] r_addr;
  logic [EE_DW-1:0] r_wdata;
  logic             r_rsp_valid;
  logic [EE_DW-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_tmo;
  ee_cmd_t          w_push_cmd;
  ee_cmd_t          w_head;
  logic [CW-1:0]    w_unused_count;

  assign w_push     = req_valid && !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push_cmd = {req_wr, req_addr, req_wdata};

  eeprom_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (w_push),
    .push_dat (w_push_cmd),
    .pop      (w_pop),
    .pop_dat  (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_unused_count)
  );

`ifdef EEPROM_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TCW-1:0] r_wd_cnt;

  // Watchdog: restarts on every pop and counts the cycles spent waiting in BUSY.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wd_cnt <= '0;
    end else if (w_pop) begin
      r_wd_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_wd_cnt <= r_wd_cnt + TCW'(1);
    end
  end

  // Expires at the end of the TIMEOUT_CYC-th BUSY cycle; ACK is checked first so it still wins.
  assign w_tmo = (r_state == BUSY) && (r_wd_cnt == TCW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  // Keeps the watchdog parameter referenced when the watchdog is compiled out.
  assign w_unused_tmo = ^TIMEOUT_CYC;
  assign w_tmo        = 1'b0;
`endif

  // Command FSM: pop in IDLE, hold strobes until ACK (or watchdog), then one RESP cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_drive     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= BUSY;
            r_wr    <= w_head.wr;
            r_rd    <= !w_head.wr;
            r_drive <= w_head.wr;
            r_addr  <= w_head.addr;
            r_wdata <= w_head.data;
          end
        end
        BUSY: begin
          if (ACK || w_tmo) begin
            r_state     <= RESP;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !ACK;
            // Read data is only meaningful on a real ACK of a read.
            r_rsp_rdata <= (ACK && r_rd) ? DATA : '0;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_wr        <= 1'b0;
          r_rd        <= 1'b0;
          r_drive     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign DATA      = r_drive ? r_wdata : {EE_DW{1'bz}};
  assign WR        = r_wr;
  assign RD        = r_rd;
  assign ADDR      = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign req_ready = !w_full;
  assign busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// tb_eeprom_cmd_seq: directed scenarios plus randomized traffic for eeprom_cmd_seq.
// Latency: n/a (testbench).
// Backpressure: host stimulus holds each request until req_ready.
module tb_eeprom_cmd_seq;
  import eeprom_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [10:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        WR;
  logic        RD;
  logic [10:0] ADDR;
  logic        ACK = 1'b0;
  wire  [7:0]  DATA;
  logic        tb_den = 1'b0;
  logic [7:0]  tb_dval = '0;

  assign DATA = tb_den ? tb_dval : 8'hzz;

  always #5 CLK = ~CLK;

  eeprom_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tfail(input string name);
    ntests++;
    nfail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Responder knobs
  int fixed_dly  = -1;
  int fixed_dval = -1;
  bit no_ack     = 1'b0;
  bit spur_en    = 1'b0;
  bit force_ack  = 1'b0;

  // Controller model: ACK after a delay, read data driven with ACK, optional stray ACKs while idle.
  initial begin : responder
    int wc;
    wc = -1;
    forever begin
      @(posedge CLK); #1;
      ACK = 1'b0;
      tb_den = 1'b0;
      if (!RESET) begin
        wc = -1;
      end else if (WR || RD) begin
        if (wc == -1) wc = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 6));
        if (wc == 0) begin
          if (!no_ack) begin
            ACK = 1'b1;
            if (RD) begin
              tb_den  = 1'b1;
              tb_dval = (fixed_dval >= 0) ? 8'(fixed_dval) : 8'($urandom);
            end
          end
          wc = -2;
        end else if (wc > 0) begin
          wc--;
        end
      end else begin
        wc = -1;
        if (force_ack || (spur_en && $urandom_range(0, 5) == 0)) ACK = 1'b1;
      end
    end
  end

  // Transaction-level reference: outstanding commands in order, one in flight at a time.
  ee_cmd_t    q[$];
  ee_cmd_t    push_cmd;
  bit         have_push = 1'b0;
  bit         inflight  = 1'b0;
  bit         p_act     = 1'b0;
  bit         p_ack     = 1'b0;
  bit         p_tmo     = 1'b0;
  bit         exp_issue = 1'b0;
  logic [7:0] p_dval    = '0;
  int         bcnt      = 0;
  int         nrsp      = 0;

  always @(negedge CLK) begin : compare
    bit         act;
    bit         issue_now;
    bit         exp_rsp;
    int         pending;
    ee_cmd_t    c;
    logic [7:0] exp_rd;
    if (!RESET) begin
      chk("rst_wr", WR, 0);
      chk("rst_rd", RD, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      q.delete();
      have_push = 0; inflight = 0; p_act = 0; p_ack = 0; p_tmo = 0; exp_issue = 0;
    end else begin
      if (have_push) q.push_back(push_cmd);
      have_push = 0;
      act = WR || RD;
      chk("wr_rd_exclusive", {31'd0, WR && RD}, 0);
      exp_rsp = p_act && (p_ack || p_tmo);
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (rsp_valid && exp_rsp && inflight && q.size() > 0) begin
        c = q.pop_front();
        inflight = 0;
        exp_rd = (!c.wr && p_ack) ? p_dval : 8'h00;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, !p_ack);
        nrsp++;
      end
      if (p_act && (p_ack || p_tmo)) chk("drop_after_ack", act, 0);
      if (p_act && !p_ack && !p_tmo) chk("hold_until_ack", act, 1);
      issue_now = act && !p_act;
      if (issue_now || exp_issue) chk("issue_timing", issue_now, exp_issue);
      if (issue_now && !inflight && q.size() > 0) begin
        inflight = 1;
        bcnt = 0;
      end
      if (act && inflight) begin
        bcnt++;
        chk("cmd_wr", WR, q[0].wr);
        chk("cmd_rd", RD, !q[0].wr);
        chk("cmd_addr", ADDR, q[0].addr);
        if (q[0].wr) chk("cmd_data", DATA, q[0].data);
      end
      pending = q.size() - (inflight ? 1 : 0);
      chk("req_ready", req_ready, pending < DEPTH);
      chk("busy", busy, act || rsp_valid || pending > 0);
      exp_issue = !act && !rsp_valid && pending > 0;
`ifdef EEPROM_TIMEOUT_EN
      p_tmo = act && inflight && !ACK && (bcnt == TMO);
`else
      p_tmo = 1'b0;
`endif
      if (req_valid && req_ready) begin
        have_push = 1;
        push_cmd  = {req_wr, req_addr, req_wdata};
      end
      p_act  = act;
      p_ack  = ACK;
      p_dval = tb_dval;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input bit wr, input logic [10:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    @(negedge CLK);
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 2000) tfail("push_wait");
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rsp_valid && n < 500);
    if (!rsp_valid) tfail(name);
  endtask

  task automatic wait_active(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(WR || RD) && n < 200);
    if (!(WR || RD)) tfail(name);
  endtask

  initial begin : main
    int n;
    int seen;
    int nb;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;

    // Write 155/A5 with ACK in the 20th strobe cycle
    fixed_dly = 19;
    push(1'b1, 11'h155, 8'hA5);
    @(negedge CLK);
    chk("t1_wr_low_after_k", WR, 0);
    @(negedge CLK);
    chk("t1_wr_high_after_k1", WR, 1);
    chk("t1_addr", ADDR, 11'h155);
    chk("t1_data", DATA, 8'hA5);
    n = 1;
    do begin
      @(negedge CLK);
      if (WR) n++;
    end while (WR && n < 100);
    chk("t1_wr_cycles", n, 20);
    chk("t1_rsp_pulse", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_rdata", rsp_rdata, 8'h00);
    @(negedge CLK);
    chk("t1_rsp_one_cycle", rsp_valid, 0);
    @(posedge CLK); #1;

    // Read 7FF, controller returns 3C
    fixed_dly = 3; fixed_dval = 8'h3C;
    push(1'b0, 11'h7FF, 8'h99);
    wait_rsp("t2_rsp");
    chk("t2_rdata", rsp_rdata, 8'h3C);
    fixed_dval = -1;
    @(posedge CLK); #1;

    // Five back-to-back requests while the first is outstanding
    fixed_dly = 30;
    nb = nrsp;
    push(1'b1, 11'h010, 8'h11);
    push(1'b0, 11'h020, 8'h22);
    push(1'b1, 11'h030, 8'h33);
    push(1'b0, 11'h040, 8'h44);
    push(1'b1, 11'h050, 8'h55);
    @(negedge CLK);
    chk("t3_full_ready_low", req_ready, 0);
    n = 0;
    while (nrsp < nb + 5 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("t3_all_done", nrsp - nb, 5);
    @(posedge CLK); #1;

    // Reset five cycles into a write with another request queued
    fixed_dly = 40;
    push(1'b1, 11'h0AA, 8'h5A);
    push(1'b0, 11'h0BB, 8'h00);
    wait_active("t4_active");
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("t4_wr_now", WR, 0);
    chk("t4_rd_now", RD, 0);
    chk("t4_ready_now", req_ready, 1);
    chk("t4_busy_now", busy, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
      if (WR || RD) seen++;
    end
    chk("t4_no_activity", seen, 0);
    chk("t4_idle", busy, 0);
    fixed_dly = -1;

    // ACK while idle and empty
    @(posedge CLK); #1;
    force_ack = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
    end
    force_ack = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid || busy) seen++;
    end
    chk("t6_idle_ack_ignored", seen, 0);
    @(posedge CLK); #1;

`ifdef EEPROM_TIMEOUT_EN
    // Watchdog: no ACK for the write, next read completes normally
    no_ack = 1'b1; fixed_dly = 0;
    push(1'b1, 11'h123, 8'h77);
    push(1'b0, 11'h321, 8'h00);
    wait_active("t5_active");
    n = 1;
    do begin
      @(negedge CLK);
      if (WR) n++;
    end while (WR && n < 200);
    no_ack = 1'b0;
    chk("t5_wr_cycles", n, TMO);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_err", rsp_err, 1);
    chk("t5_rsp_rdata", rsp_rdata, 8'h00);
    wait_rsp("t5_next_rsp");
    chk("t5_next_ok", rsp_err, 0);
    fixed_dly = -1;
    @(posedge CLK); #1;
`endif

    // Randomized traffic with random ACK delays and stray ACKs
    spur_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push(1'($urandom), 11'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
      end
    end
    n = 0;
    while ((q.size() > 0 || have_push) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() > 0 || have_push) tfail("random_drain");
    spur_en = 1'b0;
    repeat (3) @(negedge CLK);
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
